fpa_op_sequencer: RTL and testbench

Issue/collect stage wrapped around the 8-bit floating-point adder top.
- Upstream: accepts operand pairs over a valid/ready handshake, holds them stable on the adder's a/b inputs, and pulses start.
- Adder completion is not exported, so the block waits a fixed number of cycles.
- Downstream: captures ans/ans_except into a result register and presents it over valid/ready.
- Also keeps a sticky exception summary and an operation counter for the system.

---
 rtl/fpa_pkg.sv | 31 +++
 rtl/fpa_op_sequencer_if.sv | 25 ++
 rtl/fpa_op_sequencer.sv | 109 ++++++++++
 tb/tb_fpa_op_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
// Shared definitions for the FP8 adder issue/collect slice: field layout,
// widths and the sequencer state encoding.
package fpa_pkg;

    localparam int FP8_W    = 8;
    localparam int EXC_W    = 4;
    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 3;
    localparam int MANT_MSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    function automatic logic fp8_sign(input logic [FP8_W-1:0] v);
        return v[SIGN_BIT];
    endfunction

    function automatic logic [EXP_MSB-EXP_LSB:0] fp8_exp(input logic [FP8_W-1:0] v);
        return v[EXP_MSB:EXP_LSB];
    endfunction

    function automatic logic [MANT_MSB:0] fp8_mant(input logic [FP8_W-1:0] v);
        return v[MANT_MSB:0];
    endfunction

endpackage

// File: rtl/fpa_op_sequencer_if.sv
// Operand-in and result-out valid/ready channels of the FP8 op sequencer.
interface fpa_op_sequencer_if;
    import fpa_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [FP8_W-1:0]   in_a;
    logic [FP8_W-1:0]   in_b;
    logic               res_valid;
    logic               res_ready;
    logic [FP8_W-1:0]   res_data;
    logic [EXC_W-1:0]   res_except;

    // master: the surrounding system that offers operands and takes results
    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_except
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_except
    );

endinterface

// File: rtl/fpa_op_sequencer.sv
// Issue/collect stage around the FP8 adder: holds operands, pulses start,
// waits a fixed latency, then offers the captured result downstream.
module fpa_op_sequencer
    import fpa_pkg::*;
#(
    parameter int WAIT_CYC = 8,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    fpa_op_sequencer_if.slave    bus,
    output logic [FP8_W-1:0]     fpa_a,
    output logic [FP8_W-1:0]     fpa_b,
    output logic                 fpa_start,
    input  logic [FP8_W-1:0]     fpa_ans,
    input  logic [EXC_W-1:0]     fpa_except,
    output logic [EXC_W-1:0]     exc_sticky,
    input  logic                 exc_clear,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYC - 1);

    seq_state_t  state;
    seq_state_t  state_nxt;
    logic [7:0]  wait_cnt;
    logic        accept;
    logic        sample;
    logic        deliver;

    always_ff @(posedge clk) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        fpa_start     = 1'b0;
        busy          = 1'b1;
        accept        = 1'b0;
        sample        = 1'b0;
        deliver       = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                fpa_start = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == 8'd0) begin
                    sample    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    deliver   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            fpa_a          <= '0;
            fpa_b          <= '0;
            wait_cnt       <= '0;
            bus.res_data   <= '0;
            bus.res_except <= '0;
            exc_sticky     <= '0;
            op_count       <= '0;
        end else begin
            // operands stay frozen on the adder inputs until the next acceptance
            if (accept) begin
                fpa_a <= bus.in_a;
                fpa_b <= bus.in_b;
            end
            if (state == ST_START)
                wait_cnt <= WAIT_LOAD;
            else if (state == ST_WAIT && wait_cnt != 8'd0)
                wait_cnt <= wait_cnt - 8'd1;
            if (sample) begin
                bus.res_data   <= fpa_ans;
                bus.res_except <= fpa_except;
            end
            // a clear coinciding with delivery keeps only the delivered flags
            if (deliver) begin
                op_count   <= op_count + CNT_W'(1);
                exc_sticky <= (exc_clear ? '0 : exc_sticky) | bus.res_except;
            end else if (exc_clear) begin
                exc_sticky <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fpa_op_sequencer.sv
// Bench for fpa_op_sequencer with a one-cycle registered adder stub and a
// transaction-level reference model.
module tb_fpa_op_sequencer;

    localparam int WAIT_CYC = 3;
    localparam int CNT_W    = 2;
    localparam int LAT      = WAIT_CYC + 2;

    logic             clk = 1'b0;
    logic             clr;
    logic [7:0]       fpa_a, fpa_b, fpa_ans;
    logic             fpa_start;
    logic [3:0]       fpa_except, exc_sticky;
    logic             exc_clear;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;
    int model_cnt = 0;
    logic [3:0] sticky_m = 4'h0;

    fpa_op_sequencer_if bus ();

    fpa_op_sequencer #(.WAIT_CYC(WAIT_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .bus(bus.slave),
        .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_start(fpa_start),
        .fpa_ans(fpa_ans), .fpa_except(fpa_except),
        .exc_sticky(exc_sticky), .exc_clear(exc_clear),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Adder stand-in: the defined "sum" and flags of an operand pair
    function automatic logic [7:0] ref_ans(input logic [7:0] a, input logic [7:0] b);
        return a + b + 8'hE1;
    endfunction

    function automatic logic [3:0] ref_exc(input logic [7:0] a, input logic [7:0] b);
        return a[3:0] ^ b[3:0] ^ 4'h9;
    endfunction

    always_ff @(posedge clk) begin
        fpa_ans    <= ref_ans(fpa_a, fpa_b);
        fpa_except <= ref_exc(fpa_a, fpa_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation end to end; reports observed latency, start pulses and result
    task automatic issue_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                            input bit clr_hs, output int lat, output int starts,
                            output logic [7:0] d, output logic [3:0] e, output bit to);
        int n;
        to = 0; n = 0;
        while (!bus.in_ready && n < 100) begin step(); n++; end
        if (n >= 100) to = 1;
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1; starts = int'(fpa_start);
        while (!bus.res_valid && lat < 300) begin
            step(); lat++; starts += int'(fpa_start);
        end
        if (lat >= 300) to = 1;
        d = bus.res_data; e = bus.res_except;
        repeat (hold) step();
        bus.res_ready = 1'b1; exc_clear = clr_hs;
        step();
        bus.res_ready = 1'b0; exc_clear = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        step(); step();
        clr = 1'b0;
        model_cnt = 0; sticky_m = 4'h0;
        n_cmp++;
        if ({busy, bus.in_ready, bus.res_valid, fpa_start} !== 4'b0100) begin
            n_bad++; $display("FAIL reset_ctrl: got busy/rdy/rv/st=%b want 0100",
                              {busy, bus.in_ready, bus.res_valid, fpa_start});
        end
        n_cmp++;
        if ({fpa_a, fpa_b, bus.res_data, bus.res_except, exc_sticky} !== 36'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0",
                              {fpa_a, fpa_b, bus.res_data, bus.res_except, exc_sticky});
        end
        n_cmp++;
        if (op_count !== '0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d want 0", op_count);
        end
    endtask

    task automatic test_basic();
        int k;
        bus.in_a = 8'h38; bus.in_b = 8'h41; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (fpa_start !== 1'b1 || fpa_a !== 8'h38 || fpa_b !== 8'h41) begin
            n_bad++; $display("FAIL basic_start: got st=%b a=%h b=%h want 1 38 41",
                              fpa_start, fpa_a, fpa_b);
        end
        for (k = 2; k <= LAT; k++) begin
            step();
            n_cmp++;
            if (fpa_start !== 1'b0 || bus.res_valid !== (k == LAT)) begin
                n_bad++; $display("FAIL basic_timing: cyc %0d got st=%b rv=%b want 0 %b",
                                  k, fpa_start, bus.res_valid, k == LAT);
            end
        end
        n_cmp++;
        if (bus.res_data !== 8'h5A || bus.res_except !== 4'h0) begin
            n_bad++; $display("FAIL basic_result: got %h/%h want 5a/0",
                              bus.res_data, bus.res_except);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        model_cnt++;
        n_cmp++;
        if (op_count !== 2'(model_cnt) || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1
            || bus.res_data !== 8'h5A) begin
            n_bad++; $display("FAIL basic_after: got cnt=%0d rv=%b rdy=%b d=%h want 1 0 1 5a",
                              op_count, bus.res_valid, bus.in_ready, bus.res_data);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a0, b0, a1, b1, exp_d;
        int n;
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        exp_d = ref_ans(a0, b0);
        bus.in_a = a0; bus.in_b = b0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 50) begin step(); n++; end
        n_cmp++;
        if (n >= 50) begin n_bad++; $display("FAIL bp_wait: no res_valid within 50 cycles"); end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
            step();
            n_cmp++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== exp_d || bus.in_ready !== 1'b0
                || fpa_a !== a0) begin
                n_bad++; $display("FAIL bp_hold: got rv=%b d=%h rdy=%b a=%h want 1 %h 0 %h",
                                  bus.res_valid, bus.res_data, bus.in_ready, fpa_a, exp_d, a0);
            end
        end
        bus.in_a = a1; bus.in_b = b1; bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        model_cnt++; sticky_m |= ref_exc(a0, b0);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || fpa_start !== 1'b0 || fpa_a !== a0
            || op_count !== 2'(model_cnt)) begin
            n_bad++; $display("FAIL bp_handshake: got rdy=%b st=%b a=%h cnt=%0d want 1 0 %h %0d",
                              bus.in_ready, fpa_start, fpa_a, op_count, a0, model_cnt);
        end
        step();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (fpa_start !== 1'b1 || fpa_a !== a1 || fpa_b !== b1) begin
            n_bad++; $display("FAIL bp_next_accept: got st=%b a=%h b=%h want 1 %h %h",
                              fpa_start, fpa_a, fpa_b, a1, b1);
        end
        n = 0;
        while (!bus.res_valid && n < 50) begin step(); n++; end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        model_cnt++; sticky_m |= ref_exc(a1, b1);
    endtask

    task automatic test_sticky();
        logic [3:0] excs [4];
        logic [7:0] a, b, d;
        logic [3:0] e;
        int lat, st;
        bit to;
        excs[0] = 4'h1; excs[1] = 4'h0; excs[2] = 4'h4; excs[3] = 4'h2;
        exc_clear = 1'b1;
        step();
        exc_clear = 1'b0;
        sticky_m = 4'h0;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            b = {4'($urandom), a[3:0] ^ 4'h9 ^ excs[i]};
            issue_op(a, b, i, i == 3, lat, st, d, e, to);
            model_cnt++;
            n_cmp++;
            if (to || e !== excs[i] || d !== ref_ans(a, b)) begin
                n_bad++; $display("FAIL sticky_result%0d: got %h/%h to=%b want %h/%h",
                                  i, d, e, to, ref_ans(a, b), excs[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if (exc_sticky !== 4'h5) begin
                    n_bad++; $display("FAIL sticky_or: got %h want 5", exc_sticky);
                end
            end
        end
        sticky_m = 4'h2;
        n_cmp++;
        if (exc_sticky !== 4'h2) begin
            n_bad++; $display("FAIL sticky_clear_hs: got %h want 2", exc_sticky);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] a, b, d;
        logic [3:0] e;
        int lat, st;
        bit to;
        bus.in_a = 8'hC3; bus.in_b = 8'h5E; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_cnt = 0; sticky_m = 4'h0;
        n_cmp++;
        if ({busy, bus.in_ready, bus.res_valid, fpa_start} !== 4'b0100
            || {fpa_a, fpa_b, bus.res_data, bus.res_except, exc_sticky} !== 36'h0
            || op_count !== '0) begin
            n_bad++; $display("FAIL midwait_reset: got ctl=%b data=%h cnt=%0d want 0100 0 0",
                              {busy, bus.in_ready, bus.res_valid, fpa_start},
                              {fpa_a, fpa_b, bus.res_data, bus.res_except, exc_sticky}, op_count);
        end
        step(); step();
        n_cmp++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL midwait_quiet: got rv=%b busy=%b want 0 0",
                              bus.res_valid, busy);
        end
        a = 8'($urandom); b = 8'($urandom);
        issue_op(a, b, 0, 1'b0, lat, st, d, e, to);
        model_cnt++; sticky_m |= ref_exc(a, b);
        n_cmp++;
        if (to || lat != LAT || st != 1 || d !== ref_ans(a, b) || e !== ref_exc(a, b)
            || op_count !== 2'(model_cnt)) begin
            n_bad++; $display("FAIL midwait_fresh: got lat=%0d st=%0d d=%h e=%h cnt=%0d want %0d 1 %h %h %0d",
                              lat, st, d, e, op_count, LAT, ref_ans(a, b), ref_exc(a, b), model_cnt);
        end
    endtask

    task automatic test_operand_stability();
        logic [7:0] a0, b0;
        int n;
        a0 = 8'($urandom); b0 = 8'($urandom);
        bus.in_a = a0; bus.in_b = b0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
            step(); n++;
            n_cmp++;
            if (fpa_a !== a0 || fpa_b !== b0) begin
                n_bad++; $display("FAIL stable_operands: got %h/%h want %h/%h", fpa_a, fpa_b, a0, b0);
            end
        end
        n_cmp++;
        if (bus.res_data !== ref_ans(a0, b0)) begin
            n_bad++; $display("FAIL stable_result: got %h want %h", bus.res_data, ref_ans(a0, b0));
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        model_cnt++; sticky_m |= ref_exc(a0, b0);
    endtask

    task automatic test_random();
        logic [7:0] a, b, d;
        logic [3:0] e;
        int lat, st, hold;
        bit to, ch;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            hold = int'($urandom_range(0, 3)); ch = ($urandom_range(0, 3) == 0);
            issue_op(a, b, hold, ch, lat, st, d, e, to);
            model_cnt++;
            sticky_m = (ch ? 4'h0 : sticky_m) | ref_exc(a, b);
            n_cmp++;
            if (to || lat != LAT || st != 1 || d !== ref_ans(a, b) || e !== ref_exc(a, b)) begin
                n_bad++; $display("FAIL rand_op%0d: got lat=%0d st=%0d d=%h e=%h want %0d 1 %h %h",
                                  i, lat, st, d, e, LAT, ref_ans(a, b), ref_exc(a, b));
            end
            n_cmp++;
            if (op_count !== 2'(model_cnt) || exc_sticky !== sticky_m) begin
                n_bad++; $display("FAIL rand_state%0d: got cnt=%0d sticky=%h want %0d %h",
                                  i, op_count, exc_sticky, 2'(model_cnt), sticky_m);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa, pb;
        int last_start, hs, k;
        bit hs_pend;
        int exp_seq [5];
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0; exp_seq[4] = 1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_cnt = 0; sticky_m = 4'h0;
        pa = 8'($urandom); pb = 8'($urandom);
        bus.in_a = pa; bus.in_b = pb; bus.in_valid = 1'b1; bus.res_ready = 1'b1;
        last_start = -1; hs = 0; hs_pend = 0;
        for (k = 0; k < 200 && hs < 5; k++) begin
            step();
            if (hs_pend) begin
                n_cmp++;
                if (op_count !== 2'(exp_seq[hs])) begin
                    n_bad++; $display("FAIL b2b_count%0d: got %0d want %0d", hs, op_count, exp_seq[hs]);
                end
                hs++; hs_pend = 0;
            end
            if (fpa_start) begin
                n_cmp++;
                if (fpa_a !== pa || fpa_b !== pb) begin
                    n_bad++; $display("FAIL b2b_operands: got %h/%h want %h/%h", fpa_a, fpa_b, pa, pb);
                end
                if (last_start >= 0) begin
                    n_cmp++;
                    if (k - last_start != WAIT_CYC + 3) begin
                        n_bad++; $display("FAIL b2b_interval: got %0d want %0d",
                                          k - last_start, WAIT_CYC + 3);
                    end
                end
                last_start = k;
            end
            if (bus.res_valid) begin
                n_cmp++;
                if (bus.res_data !== ref_ans(pa, pb)) begin
                    n_bad++; $display("FAIL b2b_data: got %h want %h", bus.res_data, ref_ans(pa, pb));
                end
                sticky_m |= ref_exc(pa, pb);
                hs_pend = 1;
            end
            if (hs < 5) begin
                bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
                if (bus.in_ready) begin pa = bus.in_a; pb = bus.in_b; end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        n_cmp++;
        if (hs != 5) begin n_bad++; $display("FAIL b2b_budget: got %0d handshakes want 5", hs); end
        n_cmp++;
        if (exc_sticky !== sticky_m) begin
            n_bad++; $display("FAIL b2b_sticky: got %h want %h", exc_sticky, sticky_m);
        end
    endtask

    initial begin
        clr = 1'b1; exc_clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = 8'h0; bus.in_b = 8'h0; bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_sticky();
        test_reset_mid_wait();
        test_operand_stability();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
